// File: rtl/mux4_pkg.sv
// Shared definitions for the 4-channel round-robin mux scheduler.
//   NUM_CH        number of request channels
//   SEL_W         width of the mux selector / channel index
//   DEFAULT_WIDTH default data width of the mux output
//   rr_next       round-robin scan: first requester after 'start', wrapping,
//                 with 'start' itself examined last
package mux4_pkg;

    localparam int unsigned NUM_CH        = 4;
    localparam int unsigned SEL_W         = 2;
    localparam int unsigned DEFAULT_WIDTH = 3;

    // Scans start+1, start+2, start+3, start+0. Returns start when nothing requests;
    // callers qualify the result with |req.
    function automatic logic [SEL_W-1:0] rr_next(input logic [SEL_W-1:0] start,
                                                 input logic [NUM_CH-1:0] req);
        logic [SEL_W-1:0] idx;
        logic             hit;
        rr_next = start;
        hit     = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
            // SEL_W-bit add wraps modulo NUM_CH; i == NUM_CH lands on start itself
            idx = start + SEL_W'(i);
            if (!hit && req[idx]) begin
                rr_next = idx;
                hit     = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/mux4_rr_scheduler_if.sv
// Handshake/bus bundle between the scheduler, the 4-to-1 mux and the consumer.
//   request   channel requests (into scheduler)
//   grant     one-hot grant (from scheduler)
//   selector  mux selector (from scheduler)
//   enable    mux enable (from scheduler)
//   mux_out   mux result (into scheduler)
//   out_data  registered captured word (from scheduler)
//   out_valid out_data holds an unconsumed word (from scheduler)
//   out_ready consumer accepts out_data (into scheduler)
// Modport master is the scheduler side, slave the surrounding environment.
interface mux4_rr_scheduler_if #(
    parameter int unsigned WIDTH = mux4_pkg::DEFAULT_WIDTH
);
    logic [mux4_pkg::NUM_CH-1:0] request;
    logic [mux4_pkg::NUM_CH-1:0] grant;
    logic [mux4_pkg::SEL_W-1:0]  selector;
    logic                        enable;
    logic [WIDTH-1:0]            mux_out;
    logic [WIDTH-1:0]            out_data;
    logic                        out_valid;
    logic                        out_ready;

    modport master (
        input  request, mux_out, out_ready,
        output grant, selector, enable, out_data, out_valid
    );

    modport slave (
        output request, mux_out, out_ready,
        input  grant, selector, enable, out_data, out_valid
    );

endinterface

// File: rtl/mux4_rr_scheduler_pick.sv
// rr_pick4: combinational channel picker.
//   request_i    per-channel requests
//   last_grant_i channel captured most recently
//   continue_i   current streak may continue (owner still requesting, burst not exhausted)
//   pick_o       chosen channel
//   found_o      at least one channel is requesting
module rr_pick4
    import mux4_pkg::*;
(
    input  logic [NUM_CH-1:0] request_i,
    input  logic [SEL_W-1:0]  last_grant_i,
    input  logic              continue_i,
    output logic [SEL_W-1:0]  pick_o,
    output logic              found_o
);

    always_comb begin
        found_o = |request_i;
        if (continue_i) begin
            pick_o = last_grant_i;
        end else begin
            pick_o = rr_next(last_grant_i, request_i);
        end
    end

endmodule

// File: rtl/mux4_rr_scheduler.sv
// mux4_rr_scheduler: round-robin scheduler with burst allowance driving a 4-to-1 mux.
// Picks one requesting channel per cycle, steers the mux to it, captures the mux result
// into a registered valid/ready output stage and returns a one-hot grant.
//   clock  rising-edge clock
//   reset  asynchronous active-high reset
//   bus    scheduler side of mux4_rr_scheduler_if (requests, grant, mux control,
//          captured output word and its valid/ready handshake)
module mux4_rr_scheduler
    import mux4_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                clock,
    input  logic                reset,
    mux4_rr_scheduler_if.master bus
);

    localparam int unsigned        BurstW   = $clog2(MAX_BURST + 1);
    localparam logic [BurstW-1:0]  BurstMax = BurstW'(MAX_BURST);

    logic [SEL_W-1:0]  last_grant_q, last_grant_d;
    logic [BurstW-1:0] burst_q, burst_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;

    logic              can_capture;
    logic              streak_cont;
    logic              capture;
    logic [SEL_W-1:0]  pick;
    logic              found;

    assign can_capture = !out_valid_q || bus.out_ready;
    assign streak_cont = bus.request[last_grant_q] && (burst_q != '0) && (burst_q < BurstMax);

    rr_pick4 u_pick (
        .request_i    (bus.request),
        .last_grant_i (last_grant_q),
        .continue_i   (streak_cont),
        .pick_o       (pick),
        .found_o      (found)
    );

    // Combinational outputs are forced quiet while reset is asserted.
    assign capture = can_capture && found && !reset;

    always_comb begin
        bus.grant    = '0;
        bus.enable   = 1'b0;
        bus.selector = '0;
        if (capture) begin
            bus.grant    = NUM_CH'(1) << pick;
            bus.enable   = 1'b1;
            bus.selector = pick;
        end else if (!reset) begin
            // Park on the last owner so the mux input stays stable between captures.
            bus.selector = last_grant_q;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;

    always_comb begin
        last_grant_d = last_grant_q;
        burst_d      = burst_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        if (capture) begin
            out_data_d   = bus.mux_out;
            out_valid_d  = 1'b1;
            last_grant_d = pick;
            if (pick == last_grant_q && burst_q != '0) begin
                // A lone owner keeps winning past MAX_BURST; saturate so the count never
                // wraps back into the "streak may continue" range.
                burst_d = (burst_q == BurstMax) ? burst_q : burst_q + BurstW'(1);
            end else begin
                burst_d = BurstW'(1);
            end
        end else if (can_capture) begin
            // Free slot but nobody asked: the streak is broken.
            burst_d = '0;
            if (bus.out_ready) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_grant_q <= SEL_W'(NUM_CH - 1);
            burst_q      <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            burst_q      <= burst_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_mux4_rr_scheduler.sv
// Bench for mux4_rr_scheduler: three instances (MAX_BURST = 1, 2, 4) see the same
// request/out_ready stimulus; each is compared against a streak-counting reference model.
module tb_mux4_rr_scheduler;

    logic       clock;
    logic       reset;
    logic [3:0] req;
    logic       ready;

    int total = 0;
    int bad   = 0;

    mux4_rr_scheduler_if #(.WIDTH(3)) b1 ();
    mux4_rr_scheduler_if #(.WIDTH(3)) b2 ();
    mux4_rr_scheduler_if #(.WIDTH(3)) b4 ();

    // Bench-side mux: input n carries the value 4+n; disabled mux outputs 0.
    assign b1.mux_out   = b1.enable ? (3'd4 | {1'b0, b1.selector}) : 3'd0;
    assign b2.mux_out   = b2.enable ? (3'd4 | {1'b0, b2.selector}) : 3'd0;
    assign b4.mux_out   = b4.enable ? (3'd4 | {1'b0, b4.selector}) : 3'd0;
    assign b1.request   = req;
    assign b2.request   = req;
    assign b4.request   = req;
    assign b1.out_ready = ready;
    assign b2.out_ready = ready;
    assign b4.out_ready = ready;

    mux4_rr_scheduler #(.WIDTH(3), .MAX_BURST(1)) u_dut1 (
        .clock (clock), .reset (reset), .bus (b1)
    );
    mux4_rr_scheduler #(.WIDTH(3), .MAX_BURST(2)) u_dut2 (
        .clock (clock), .reset (reset), .bus (b2)
    );
    mux4_rr_scheduler #(.WIDTH(3), .MAX_BURST(4)) u_dut4 (
        .clock (clock), .reset (reset), .bus (b4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: streak is the number of consecutive captures by the same channel
    // since the last idle slot (unbounded integer).
    int         m_max    [3] = '{1, 2, 4};
    int         m_last   [3];
    int         m_streak [3];
    logic       m_valid  [3];
    logic [2:0] m_data   [3];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic sample(input int k, output logic [3:0] g, output logic [1:0] s,
                          output logic e, output logic [2:0] d, output logic v);
        case (k)
            0: begin g = b1.grant; s = b1.selector; e = b1.enable; d = b1.out_data; v = b1.out_valid; end
            1: begin g = b2.grant; s = b2.selector; e = b2.enable; d = b2.out_data; v = b2.out_valid; end
            default: begin
                g = b4.grant; s = b4.selector; e = b4.enable; d = b4.out_data; v = b4.out_valid;
            end
        endcase
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_last[k]   = 3;
            m_streak[k] = 0;
            m_valid[k]  = 1'b0;
            m_data[k]   = 3'd0;
        end
    endtask

    function automatic int model_pick(input int k, input logic [3:0] r);
        if (r[m_last[k]] && m_streak[k] > 0 && m_streak[k] < m_max[k]) return m_last[k];
        for (int i = 1; i <= 4; i++) begin
            if (r[(m_last[k] + i) % 4]) return (m_last[k] + i) % 4;
        end
        return -1;
    endfunction

    // All outputs must read zero (used while reset is high).
    task automatic check_quiet(input string tag);
        logic [3:0] g; logic [1:0] s; logic e; logic [2:0] d; logic v;
        for (int k = 0; k < 3; k++) begin
            sample(k, g, s, e, d, v);
            check_val($sformatf("%s_grant_b%0d", tag, m_max[k]), 32'(g), 32'd0);
            check_val($sformatf("%s_enable_b%0d", tag, m_max[k]), 32'(e), 32'd0);
            check_val($sformatf("%s_sel_b%0d", tag, m_max[k]), 32'(s), 32'd0);
            check_val($sformatf("%s_valid_b%0d", tag, m_max[k]), 32'(v), 32'd0);
            check_val($sformatf("%s_data_b%0d", tag, m_max[k]), 32'(d), 32'd0);
        end
    endtask

    // One clock: called at a falling edge, returns at the next falling edge.
    task automatic step(input string tag, input logic [3:0] r, input logic rdy);
        int         p   [3];
        logic       cap [3];
        logic [3:0] g; logic [1:0] s; logic e; logic [2:0] d; logic v;
        req   = r;
        ready = rdy;
        #1;
        for (int k = 0; k < 3; k++) begin
            p[k]   = model_pick(k, r);
            cap[k] = (!m_valid[k] || rdy) && (r != 4'd0);
            sample(k, g, s, e, d, v);
            check_val($sformatf("%s_valid_b%0d", tag, m_max[k]), 32'(v), 32'(m_valid[k]));
            check_val($sformatf("%s_data_b%0d", tag, m_max[k]), 32'(d), 32'(m_data[k]));
            check_val($sformatf("%s_enable_b%0d", tag, m_max[k]), 32'(e), 32'(cap[k]));
            check_val($sformatf("%s_grant_b%0d", tag, m_max[k]), 32'(g),
                      cap[k] ? (32'd1 << p[k]) : 32'd0);
            check_val($sformatf("%s_sel_b%0d", tag, m_max[k]), 32'(s),
                      cap[k] ? 32'(p[k]) : 32'(m_last[k]));
        end
        @(posedge clock);
        for (int k = 0; k < 3; k++) begin
            if (cap[k]) begin
                m_data[k]   = 3'(4 + p[k]);
                m_valid[k]  = 1'b1;
                m_streak[k] = (p[k] == m_last[k] && m_streak[k] > 0) ? m_streak[k] + 1 : 1;
                m_last[k]   = p[k];
            end else if (!m_valid[k] || rdy) begin
                m_streak[k] = 0;
                if (rdy) m_valid[k] = 1'b0;
            end
        end
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b1;
        req   = 4'b1111;
        ready = 1'b1;
        model_reset();
        @(negedge clock);
        @(negedge clock);
        check_quiet("init_rst");
        reset = 1'b0;

        // All channels requesting: pure RR on MAX_BURST=1, bursts on the others.
        for (int i = 0; i < 10; i++) step("all_req", 4'b1111, 1'b1);
        // Two-channel burst alternation.
        for (int i = 0; i < 20; i++) step("burst", 4'b0101, 1'b1);
        // Backpressure: word held, no captures, then resume.
        step("bp_fill", 4'b1111, 1'b1);
        for (int i = 0; i < 3; i++) step("bp_stall", 4'b1111, 1'b0);
        for (int i = 0; i < 4; i++) step("bp_resume", 4'b1111, 1'b1);
        // Lone requester keeps winning, no bubbles.
        for (int i = 0; i < 6; i++) step("lone", 4'b1000, 1'b1);
        // Idle slot breaks the streak.
        step("gap_a", 4'b0010, 1'b1);
        step("gap_b", 4'b0010, 1'b1);
        step("gap_idle", 4'b0000, 1'b1);
        for (int i = 0; i < 4; i++) step("gap_after", 4'b0011, 1'b1);
        // Drain with no requests.
        step("drain", 4'b0000, 1'b1);
        step("drain", 4'b0000, 1'b1);

        // Random traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            step("rand", 4'($urandom), ($urandom_range(0, 3) != 0));
        end

        // Reset in the middle of a cycle with a word pending.
        step("pre_rst", 4'b1111, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check_quiet("mid_rst");
        model_reset();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) step("post_rst", 4'b1111, 1'b1);
        for (int i = 0; i < 100; i++) begin
            step("rand2", 4'($urandom), ($urandom_range(0, 1) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
